// File: rtl/gzip_stream_sequencer_pkg.sv
// rtl/gzip_stream_sequencer_pkg.sv - shared state encoding and LED bit map for the gzip stream sequencer
package gzip_stream_sequencer_pkg;

    // Sequencer states
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] STREAM    = 2'd1;
    localparam logic [1:0] FLUSH     = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    // o_led bit positions
    localparam int LED_ACTIVE    = 0;   // STREAM or FLUSH
    localparam int LED_WAIT_DONE = 1;
    localparam int LED_OVERFLOW  = 2;
    localparam int LED_NONEMPTY  = 3;

endpackage

// File: rtl/stream_byte_fifo.sv
// rtl/stream_byte_fifo.sv - synchronous 8-bit show-ahead FIFO with full/empty flags
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset (pointers only)
//   wr_en, wr_data     push request and byte; ignored while full
//   rd_en              pop request; ignored while empty
//   rd_data            byte at the head (valid whenever empty is low)
//   full, empty        occupancy flags derived from the registered pointers
module stream_byte_fifo #(
    parameter int AW = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);

    // Pointers carry one extra MSB so full and empty are distinguishable
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [0:(1<<AW)-1];
    logic        do_wr;
    logic        do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/gzip_stream_sequencer.sv
// rtl/gzip_stream_sequencer.sv - buffers UART RX bytes and frames them into tlast-terminated compressor streams
//
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   i_rx_tvalid, i_rx_tdata        one-cycle received-byte strobe and byte (cannot be stalled)
//   o_tvalid, i_tready, o_tdata,   byte stream towards the compressor; o_tlast marks end of file
//   o_tlast
//   i_done                         compressor finished the gzip trailer
//   o_len_valid, o_len             completed-stream length pulse and value (saturating)
//   o_overflow                     sticky: an RX byte was dropped because the FIFO was full
//   o_led                          status lamps, bit map in the package
module gzip_stream_sequencer
    import gzip_stream_sequencer_pkg::*;
#(
    parameter int unsigned IDLE_TIMEOUT = 10000000,
    parameter int          FIFO_AW      = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_rx_tvalid,
    input  logic [7:0]  i_rx_tdata,
    output logic        o_tvalid,
    input  logic        i_tready,
    output logic [7:0]  o_tdata,
    output logic        o_tlast,
    input  logic        i_done,
    output logic        o_len_valid,
    output logic [31:0] o_len,
    output logic        o_overflow,
    output logic [3:0]  o_led
);

    localparam logic [31:0] TIMEOUT_LAST = 32'(IDLE_TIMEOUT - 1);

    logic [1:0]  state;
    logic        pend_v;
    logic [7:0]  pend_d;
    logic [31:0] len_cnt;
    logic [31:0] len_next;
    logic [31:0] to_cnt;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_head;
    logic        fifo_pop;
    logic        handshake;

    stream_byte_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (i_rx_tvalid),
        .wr_data (i_rx_tdata),
        .rd_en   (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // The pending byte is only offered in STREAM while another byte is queued
    // behind it; otherwise it might turn out to be the last byte and need tlast.
    always_comb begin
        o_tvalid = 1'b0;
        o_tlast  = 1'b0;
        case (state)
            STREAM:  o_tvalid = pend_v && !fifo_empty;
            FLUSH: begin
                o_tvalid = 1'b1;
                o_tlast  = 1'b1;
            end
            default: o_tvalid = 1'b0;
        endcase
    end

    assign o_tdata   = pend_d;
    assign handshake = o_tvalid && i_tready;
    assign fifo_pop  = ((state == IDLE) && !fifo_empty) || ((state == STREAM) && handshake);
    assign len_next  = (len_cnt == 32'hFFFF_FFFF) ? len_cnt : len_cnt + 32'd1;

    always_comb begin
        o_led                = '0;
        o_led[LED_ACTIVE]    = (state == STREAM) || (state == FLUSH);
        o_led[LED_WAIT_DONE] = (state == WAIT_DONE);
        o_led[LED_OVERFLOW]  = o_overflow;
        o_led[LED_NONEMPTY]  = !fifo_empty;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            pend_v      <= 1'b0;
            pend_d      <= '0;
            len_cnt     <= '0;
            to_cnt      <= '0;
            o_len_valid <= 1'b0;
            o_len       <= '0;
            o_overflow  <= 1'b0;
        end else begin
            o_len_valid <= 1'b0;
            // The full flag is registered, so a same-cycle pop does not make room
            if (i_rx_tvalid && fifo_full) o_overflow <= 1'b1;

            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        pend_v  <= 1'b1;
                        pend_d  <= fifo_head;
                        len_cnt <= '0;
                        to_cnt  <= '0;
                        state   <= STREAM;
                    end
                end
                STREAM: begin
                    if (handshake) begin
                        pend_d  <= fifo_head;
                        len_cnt <= len_next;
                    end
                    // Silence is measured only once everything but the pending byte has left
                    if (i_rx_tvalid) begin
                        to_cnt <= '0;
                    end else if (fifo_empty) begin
                        if (to_cnt == TIMEOUT_LAST) state <= FLUSH;
                        else                         to_cnt <= to_cnt + 32'd1;
                    end
                end
                FLUSH: begin
                    if (handshake) begin
                        pend_v      <= 1'b0;
                        len_cnt     <= len_next;
                        o_len       <= len_next;
                        o_len_valid <= 1'b1;
                        state       <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (i_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
